muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Iterative multiply/divide sequencer for the EX stage of the 5-stage pipelined CPU. It accepts MIPS `mult`/`multu`/`div`/`divu` from the decoded funct field and runs a 32-step shift-add or restoring-divide sequence. It owns the HI/LO registers and stalls the pipeline while a new muldiv, `mfhi` or `mflo` arrives during an operation. It sits beside the ALU and its ALU controller; the ALU is not used for muldiv.

## Interface
- No parameters; datapath width fixed at 32 bits.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: EX-stage instruction is a valid muldiv (funct below).
- `funct_i` in 6: 011000 mult, 011001 multu, 011010 div, 011011 divu; any other value with `start_i`=1 is ignored.
- `mfhilo_i` in 1: EX-stage instruction is `mfhi`/`mflo`.
- `src1_i` in 32: rs operand (multiplicand / dividend).
- `src2_i` in 32: rt operand (multiplier / divisor).
- `busy_o` out 1: operation in progress.
- `stall_o` out 1: combinational, `busy_o & (start_i | mfhilo_i)`; freezes IF/ID/EX.
- `done_o` out 1: one-cycle pulse when new HI/LO become visible.
- `hi_o` out 32: HI register (product high / remainder).
- `lo_o` out 32: LO register (product low / quotient).

## Operation
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `hi_o`=0, `lo_o`=0, step counter 0.
- States:
  - IDLE: on `start_i` with a legal funct, latch operand magnitudes, result-sign flags and op type. Go to CALC, or to FIX for a divide with `src2_i`=0.
  - CALC: one step per cycle, counter 0..31. Exit to FIX after step 31.
  - FIX: apply sign correction, write HI/LO, then go to DONE.
  - DONE: `done_o`=1 for one cycle. Behaves as IDLE, so a start is accepted in this cycle.
- Signed ops (mult, div) work on magnitudes of both operands.
- Multiply:
  - 64-bit unsigned shift-add.
  - For mult, the 64-bit result is negated in FIX when the operand signs differ.
  - HI = bits 63:32, LO = bits 31:0.
- Divide:
  - Restoring division on magnitudes.
  - For div, the quotient is negated when the signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0; no trap.
- Divide by zero (`src2_i`=0): no iteration; LO=0xFFFFFFFF, HI=`src1_i` (raw, unsigned interpretation).
- `start_i` while busy is not accepted. `stall_o` holds the instruction in EX, and it is re-presented and accepted in the DONE cycle.
- `mfhilo_i` while busy asserts `stall_o`. The first cycle with `busy_o`=0 returns the new HI/LO.
- HI/LO hold their value except at the FIX write.

## Timing
- Cycle 0: `start_i` sampled at the rising edge ending cycle 0.
- `busy_o`=1 in cycles 1..33 (CALC 1..32, FIX 33).
- Cycle 34: `hi_o`/`lo_o` show the result, `done_o`=1 and `busy_o`=0.
- Latency is 34 cycles start-to-result.
- Divide by zero: FIX in cycle 1, result and `done_o` in cycle 2.
- Back-to-back: a start in a DONE cycle gives its result 34 cycles later, with no dead cycle.
- `rst_i` in any cycle, including mid-CALC: next cycle is IDLE with all outputs at reset values. No `done_o` is produced for the aborted op.
- `rst_i` and `start_i` together: reset wins and the start is dropped.

## Configuration
- Macro `MULDIV_RADIX4_EN`:
  - Defined: multiply retires 2 multiplier bits per CALC cycle, using the counter 0..15. Multiply latency becomes 18 cycles (busy cycles 1..17, result in cycle 18).
  - Undefined: radix-2, 34 cycles.
- Divide timing and all results are identical in both builds.

## Test plan
- mult 7 × 0xFFFFFFFD (−3) -> cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done_o` one-cycle pulse (cycle 18 with `MULDIV_RADIX4_EN`).
- multu 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- div 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 100 / 7 -> LO=0x0000000E, HI=0x00000002.
- div 0x00001234 / 0 -> cycle 2: LO=0xFFFFFFFF, HI=0x00001234, `done_o`=1.
- Second mult issued in cycle 5 while busy -> `stall_o`=1 cycles 5..33. The first result appears in cycle 34, the second op is accepted in cycle 34 and its result appears in cycle 68.
- `mfhilo_i` in cycle 10 -> `stall_o`=1 until cycle 34.
- `rst_i` in cycle 10 of a mult -> cycle 11: `busy_o`=0, HI=LO=0. No `done_o` ever pulses for the aborted mult.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS mult/multu/div/divu sequencer owning HI/LO; stalls EX while busy.
// Build option: define MULDIV_RADIX4_EN for a radix-4 multiply (2 multiplier bits per cycle).
module muldiv_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [5:0]  funct_i,
  input  logic        mfhilo_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PLEN  = 2 * XLEN;
  localparam int unsigned CNT_W = 5;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(31);
`ifdef MULDIV_RADIX4_EN
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(15);
`else
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(31);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PLEN-1:0]   p_q, p_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // Operand decode: funct 0110xx is the muldiv group, bit0 = unsigned, bit1 = divide.
  logic            legal_c;
  logic            sgn_c;
  logic            div_in_c;
  logic            a_neg_c;
  logic            b_neg_c;
  logic [XLEN-1:0] a_mag_c;
  logic [XLEN-1:0] b_mag_c;

  assign legal_c  = (funct_i[5:2] == 4'b0110);
  assign sgn_c    = ~funct_i[0];
  assign div_in_c = funct_i[1];
  assign a_neg_c  = sgn_c & src1_i[XLEN-1];
  assign b_neg_c  = sgn_c & src2_i[XLEN-1];
  assign a_mag_c  = a_neg_c ? (~src1_i + XLEN'(1)) : src1_i;
  assign b_mag_c  = b_neg_c ? (~src2_i + XLEN'(1)) : src2_i;

  // Multiply step: p holds {partial product high, remaining multiplier bits}.
  logic [PLEN-1:0] mul_next_c;
`ifdef MULDIV_RADIX4_EN
  logic [XLEN+1:0] mul_add_c;
  logic [XLEN+1:0] mul_sum_c;
  always_comb begin
    mul_add_c = '0;
    case (p_q[1:0])
      2'b01:   mul_add_c = {2'b00, opnd_q};
      2'b10:   mul_add_c = {1'b0, opnd_q, 1'b0};
      2'b11:   mul_add_c = {2'b00, opnd_q} + {1'b0, opnd_q, 1'b0};
      default: mul_add_c = '0;
    endcase
    mul_sum_c  = {2'b00, p_q[PLEN-1:XLEN]} + mul_add_c;
    mul_next_c = {mul_sum_c, p_q[XLEN-1:2]};
  end
`else
  logic [XLEN:0] mul_sum_c;
  always_comb begin
    mul_sum_c  = {1'b0, p_q[PLEN-1:XLEN]} + (p_q[0] ? {1'b0, opnd_q} : (XLEN+1)'(0));
    mul_next_c = {mul_sum_c, p_q[XLEN-1:1]};
  end
`endif

  // Restoring divide step: p holds {partial remainder, dividend/quotient bits}.
  logic [XLEN:0]   div_shift_c;
  logic            div_fit_c;
  logic [XLEN-1:0] div_diff_c;
  logic [PLEN-1:0] div_next_c;

  always_comb begin
    div_shift_c = p_q[PLEN-1:XLEN-1];
    div_fit_c   = (div_shift_c >= {1'b0, opnd_q});
    div_diff_c  = div_shift_c[XLEN-1:0] - opnd_q;
    div_next_c  = div_fit_c ? {div_diff_c, p_q[XLEN-2:0], 1'b1}
                            : {div_shift_c[XLEN-1:0], p_q[XLEN-2:0], 1'b0};
  end

  // Sign correction applied in FIX.
  logic [PLEN-1:0] prod_fix_c;
  logic [XLEN-1:0] quo_fix_c;
  logic [XLEN-1:0] rem_fix_c;

  assign prod_fix_c = neg_res_q ? (~p_q + PLEN'(1)) : p_q;
  assign quo_fix_c  = neg_res_q ? (~p_q[XLEN-1:0] + XLEN'(1)) : p_q[XLEN-1:0];
  assign rem_fix_c  = neg_rem_q ? (~p_q[PLEN-1:XLEN] + XLEN'(1)) : p_q[PLEN-1:XLEN];

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i && legal_c) begin
          is_div_d  = div_in_c;
          cnt_d     = '0;
          busy_d    = 1'b1;
          neg_res_d = a_neg_c ^ b_neg_c;
          neg_rem_d = a_neg_c;
          if (div_in_c) begin
            opnd_d = b_mag_c;
            p_d    = {{XLEN{1'b0}}, a_mag_c};
          end else begin
            opnd_d = a_mag_c;
            p_d    = {{XLEN{1'b0}}, b_mag_c};
          end
          if (div_in_c && (src2_i == '0)) begin
            // Divide by zero skips iteration; FIX passes p through unchanged.
            p_d       = {src1_i, {XLEN{1'b1}}};
            neg_res_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        busy_d = 1'b1;
        p_d    = is_div_q ? div_next_c : mul_next_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == (is_div_q ? DIV_LAST : MUL_LAST)) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        if (is_div_q) begin
          hi_d = rem_fix_c;
          lo_d = quo_fix_c;
        end else begin
          hi_d = prod_fix_c[PLEN-1:XLEN];
          lo_d = prod_fix_c[XLEN-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign stall_o = busy_q & (start_i | mfhilo_i);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed and random ops against an arithmetic model.
module tb_muldiv_ctrl;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
`ifdef MULDIV_RADIX4_EN
  localparam int MUL_LAT = 18;
`else
  localparam int MUL_LAT = 34;
`endif
  localparam int DIV_LAT = 34;
  localparam int DZ_LAT  = 2;

  logic        clk = 1'b0;
  logic        rst_i, start_i, mfhilo_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i, src2_i;
  logic        busy_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  muldiv_ctrl dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .funct_i (funct_i),
    .mfhilo_i(mfhilo_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .busy_o  (busy_o),
    .stall_o (stall_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference: plain 64-bit arithmetic on the MIPS semantics.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint sa, sb, sr;
    logic [63:0] up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = '0; lo = '0; lat = 0;
    if ((f == FN_DIV || f == FN_DIVU) && b == 32'd0) begin
      hi = a; lo = 32'hFFFFFFFF; lat = DZ_LAT;
    end else if (f == FN_MULT) begin
      sr = sa * sb; up = 64'(sr);
      hi = up[63:32]; lo = up[31:0]; lat = MUL_LAT;
    end else if (f == FN_MULTU) begin
      up = {32'd0, a} * {32'd0, b};
      hi = up[63:32]; lo = up[31:0]; lat = MUL_LAT;
    end else if (f == FN_DIV) begin
      uq = 64'(sa / sb); ur = 64'(sa % sb);
      hi = ur[31:0]; lo = uq[31:0]; lat = DIV_LAT;
    end else begin
      uq = {32'd0, a} / {32'd0, b}; ur = {32'd0, a} % {32'd0, b};
      hi = ur[31:0]; lo = uq[31:0]; lat = DIV_LAT;
    end
  endfunction

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b1; funct_i = FN_MULT; mfhilo_i = 1'b0;
    src1_i = 32'd5; src2_i = 32'd6;
    tick(); tick();
    rst_i = 1'b0; start_i = 1'b0; mfhilo_i = 1'b1;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b stall=%b hi=%h lo=%h expected all zero",
               busy_o, done_o, stall_o, hi_o, lo_o);
    end
    mfhilo_i = 1'b0;
    tick();
  endtask

  task automatic test_arith();
    logic [5:0]  fq[$];
    logic [31:0] aq[$], bq[$];
    logic [5:0]  fns[4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    logic [31:0] mh, ml;
    int lat;
    bit ok;
    fq = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_DIV, FN_DIV, FN_DIVU, FN_MULT};
    aq = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h00001234, 32'h80000000, 32'hDEADBEEF, 32'h80000000};
    bq = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'd0, 32'h80000000};
    for (int i = 0; i < 24; i++) begin
      fq.push_back(fns[$urandom_range(0, 3)]);
      aq.push_back(pick_opnd());
      bq.push_back(pick_opnd());
    end
    foreach (fq[i]) begin
      model(fq[i], aq[i], bq[i], mh, ml, lat);
      start_i = 1'b1; funct_i = fq[i]; src1_i = aq[i]; src2_i = bq[i];
      tick();
      start_i = 1'b0; src1_i = 32'($urandom); src2_i = 32'($urandom);
      ok = 1'b1;
      for (int c = 1; c < lat; c++) begin
        if (busy_o !== 1'b1 || done_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) ok = 1'b0;
        tick();
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL arith_busy op%0d f=%b: busy/done/HI/LO not held during op (now busy=%b done=%b hi=%h lo=%h) expected busy=1 done=0 hi=%h lo=%h",
                 i, fq[i], busy_o, done_o, hi_o, lo_o, exp_hi, exp_lo);
      end
      exp_hi = mh; exp_lo = ml;
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b1 || hi_o !== exp_hi || lo_o !== exp_lo) begin
        errors++;
        $display("FAIL arith_result op%0d f=%b a=%h b=%h cyc=%0d: busy=%b done=%b hi=%h lo=%h expected busy=0 done=1 hi=%h lo=%h",
                 i, fq[i], aq[i], bq[i], lat, busy_o, done_o, hi_o, lo_o, exp_hi, exp_lo);
      end
      tick();
      checks++;
      if (done_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
        errors++;
        $display("FAIL arith_pulse op%0d: done=%b hi=%h lo=%h expected done=0 hi=%h lo=%h",
                 i, done_o, hi_o, lo_o, exp_hi, exp_lo);
      end
    end
  endtask

  task automatic test_illegal();
    start_i = 1'b1; funct_i = 6'b100000; src1_i = 32'd3; src2_i = 32'd4;
    tick();
    start_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
      errors++;
      $display("FAIL illegal_funct: busy=%b done=%b hi=%h lo=%h expected busy=0 done=0 hi=%h lo=%h",
               busy_o, done_o, hi_o, lo_o, exp_hi, exp_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, h1, l1, h2, l2;
    int lat;
    bit ok;
    a1 = pick_opnd(); b1 = pick_opnd(); a2 = pick_opnd(); b2 = pick_opnd();
    model(FN_MULT, a1, b1, h1, l1, lat);
    model(FN_MULT, a2, b2, h2, l2, lat);
    start_i = 1'b1; funct_i = FN_MULT; src1_i = a1; src2_i = b1;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    start_i = 1'b1; src1_i = a2; src2_i = b2;
    #1;
    ok = 1'b1;
    for (int c = 5; c < lat; c++) begin
      if (stall_o !== 1'b1) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_stall: stall dropped before cycle %0d (now stall=%b) expected 1", lat, stall_o);
    end
    exp_hi = h1; exp_lo = l1;
    checks++;
    if (stall_o !== 1'b0 || done_o !== 1'b1 || hi_o !== exp_hi || lo_o !== exp_lo) begin
      errors++;
      $display("FAIL b2b_first: stall=%b done=%b hi=%h lo=%h expected stall=0 done=1 hi=%h lo=%h",
               stall_o, done_o, hi_o, lo_o, exp_hi, exp_lo);
    end
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b done=%b expected busy=1 done=0", busy_o, done_o);
    end
    for (int c = lat + 1; c < 2 * lat; c++) tick();
    exp_hi = h2; exp_lo = l2;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b1 || hi_o !== exp_hi || lo_o !== exp_lo) begin
      errors++;
      $display("FAIL b2b_second: busy=%b done=%b hi=%h lo=%h expected busy=0 done=1 hi=%h lo=%h",
               busy_o, done_o, hi_o, lo_o, exp_hi, exp_lo);
    end
    tick();
  endtask

  task automatic test_mfhilo();
    logic [31:0] a, b, h, l;
    int lat;
    bit ok;
    a = pick_opnd(); b = pick_opnd();
    model(FN_MULTU, a, b, h, l, lat);
    start_i = 1'b1; funct_i = FN_MULTU; src1_i = a; src2_i = b;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    mfhilo_i = 1'b1;
    #1;
    ok = 1'b1;
    for (int c = 10; c < lat; c++) begin
      if (stall_o !== 1'b1) ok = 1'b0;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mfhilo_stall: stall dropped before cycle %0d (now stall=%b) expected 1", lat, stall_o);
    end
    exp_hi = h; exp_lo = l;
    checks++;
    if (stall_o !== 1'b0 || hi_o !== exp_hi || lo_o !== exp_lo) begin
      errors++;
      $display("FAIL mfhilo_read: stall=%b hi=%h lo=%h expected stall=0 hi=%h lo=%h",
               stall_o, hi_o, lo_o, exp_hi, exp_lo);
    end
    mfhilo_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_i = 1'b1; funct_i = FN_MULT; src1_i = 32'd7; src2_i = 32'hFFFFFFFD;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_hi = '0; exp_lo = '0;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h expected all zero", busy_o, done_o, hi_o, lo_o);
    end
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_abort: aborted op showed busy/done=1 expected 0");
    end
    rst_i = 1'b1; start_i = 1'b1; funct_i = FN_DIVU; src1_i = 32'd9; src2_i = 32'd0;
    tick();
    rst_i = 1'b0; start_i = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'd0 || lo_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_start: busy=%b done=%b hi=%h lo=%h expected all zero", busy_o, done_o, hi_o, lo_o);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_illegal();
    test_back_to_back();
    test_mfhilo();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
